// File: rtl/shape_color_classifier.sv
// Classifies each camera frame by colour (none/red/blue) and shape (plain/diamond/triangle)
// from an RGB332 pixel stream, with stability voting, a VALID/ACK result port and debug video.
module shape_color_classifier #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ROI_X_MIN     = 35,
    parameter int CNT_W         = 24,
    parameter int DIAG_W        = 12,
    parameter int IIR_SHIFT     = 4,
    parameter int COLOR_TH      = 6000,
    parameter int DIA_TH        = 18,
    parameter int TRI_TH        = 18,
    parameter int STABLE_FRAMES = 3
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] PIXEL_IN,
    input  logic [9:0] PIXEL_X,
    input  logic [9:0] PIXEL_Y,
    input  logic       VGA_VSYNC_NEG,
    input  logic [1:0] MODE,
    input  logic       RESULT_ACK,
    output logic [7:0] PIXEL_OUT,
    output logic [2:0] RESULT,
    output logic       RESULT_VALID
);

    localparam int XW     = $clog2(SCREEN_WIDTH);
    localparam int CNT_W1 = CNT_W + 1;
    localparam int STAB_W = $clog2(STABLE_FRAMES + 1);

    localparam logic [9:0]          ROI_LO    = 10'(ROI_X_MIN);
    localparam logic [9:0]          X_END     = 10'(SCREEN_WIDTH);
    localparam logic [9:0]          Y_END     = 10'(SCREEN_HEIGHT);
    localparam logic [9:0]          X_IN_HI   = 10'(SCREEN_WIDTH - 3);
    localparam logic [9:0]          Y_IN_HI   = 10'(SCREEN_HEIGHT - 3);
    localparam logic [CNT_W:0]      COL_TH_W  = CNT_W1'(COLOR_TH);
    localparam logic [CNT_W:0]      COL_HALF  = CNT_W1'(COLOR_TH / 2);
    localparam logic [DIAG_W-1:0]   DIA_TH_W  = DIAG_W'(DIA_TH);
    localparam logic [DIAG_W-1:0]   TRI_TH_W  = DIAG_W'(TRI_TH);
    localparam logic [STAB_W-1:0]   STAB_MAX  = STAB_W'(STABLE_FRAMES);
    localparam logic [STAB_W-1:0]   STAB_ONE  = 1;
    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [DIAG_W-1:0]   DIAG_ONE  = 1;
    localparam logic [XW-1:0]       X_ONE     = 1;
    localparam logic [XW-1:0]       X_TWO     = 2;
    localparam logic [SCREEN_WIDTH-1:0] ROW_BIT0 = 1;

    typedef enum logic [1:0] {ST_WAIT, ST_ACCUM, ST_FILT, ST_DECIDE} state_t;

    typedef struct packed {
        logic [SCREEN_WIDTH-1:0] p2;
        logic [SCREEN_WIDTH-1:0] p1;
        logic [SCREEN_WIDTH-1:0] c;
    } rows_t;

    state_t              state, state_n;
    logic                vs_q, y_chg_unused_guard;
    logic [9:0]          y_q;
    rows_t               rows_b, rows_r, rows_b_n, rows_r_n;
    logic [CNT_W-1:0]    blue_cnt, red_cnt, blue_p, red_p;
    logic [DIAG_W-1:0]   up_b_cnt, dn_b_cnt, up_r_cnt, dn_r_cnt;
    logic [DIAG_W-1:0]   up_b_p, dn_b_p, up_r_p, dn_r_p;
    logic [2:0]          cand, last_cand;
    logic [STAB_W-1:0]   stab_cnt, stab_next;
    logic [7:0]          pix_d;
    logic                clr_raw, update;

    logic [2:0] r_f, g_f;
    logic [1:0] b_f;
    logic       blue_f, red_f, in_roi, interior, y_chg, vs_rise, vs_fall;
    logic [XW-1:0] x0, x1, x2;
    logic [8:0] win_b, win_r;
    logic       up_b, dn_b, up_r, dn_r;

    // Shift the three flag rows on a new line, then drop the current pixel's flag into cur.
    function automatic rows_t advance(rows_t q, logic shift, logic wr, logic [9:0] x);
        rows_t n;
        n = q;
        if (shift) begin
            n.p2 = q.p1;
            n.p1 = q.c;
            n.c  = '0;
        end
        if (wr)
            n.c = n.c | (ROW_BIT0 << x);
        return n;
    endfunction

    function automatic logic [8:0] window(rows_t n, logic [XW-1:0] xl, logic [XW-1:0] xm,
                                          logic [XW-1:0] xr);
        return {n.p2[xl], n.p2[xm], n.p2[xr], n.p1[xl], n.p1[xm], n.p1[xr],
                n.c[xl], n.c[xm], n.c[xr]};
    endfunction

    function automatic logic up_hit(logic [8:0] w);
        return (w == 9'b111_110_100) || (w == 9'b111_011_001);
    endfunction

    function automatic logic dn_hit(logic [8:0] w);
        return (w == 9'b001_011_111) || (w == 9'b100_110_111);
    endfunction

    // Intermediate is one bit wider; p - p/2^k + raw/2^k never exceeds the counter range.
    function automatic logic [CNT_W-1:0] iir_cnt(logic [CNT_W-1:0] p, logic [CNT_W-1:0] raw);
        logic [CNT_W:0] acc;
        acc = {1'b0, p} - {1'b0, p >> IIR_SHIFT} + {1'b0, raw >> IIR_SHIFT};
        return acc[CNT_W-1:0];
    endfunction

    function automatic logic [DIAG_W-1:0] iir_diag(logic [DIAG_W-1:0] p, logic [DIAG_W-1:0] raw);
        logic [DIAG_W:0] acc;
        acc = {1'b0, p} - {1'b0, p >> IIR_SHIFT} + {1'b0, raw >> IIR_SHIFT};
        return acc[DIAG_W-1:0];
    endfunction

    assign {r_f, g_f, b_f} = PIXEL_IN;
    assign blue_f   = (r_f < 3'd2) && (g_f < 3'd2) && (b_f <= 2'd2);
    assign red_f    = ((r_f >= 3'd3) && (g_f <= 3'd2) && (b_f <= 2'd2)) ||
                      ((r_f > g_f) && (r_f[2:1] >= b_f));
    assign in_roi   = (PIXEL_X > ROI_LO) && (PIXEL_X < X_END) && (PIXEL_Y < Y_END);
    assign interior = (PIXEL_X >= 10'd2) && (PIXEL_X <= X_IN_HI) &&
                      (PIXEL_Y >= 10'd2) && (PIXEL_Y <= Y_IN_HI);
    assign y_chg    = (PIXEL_Y != y_q);
    assign vs_rise  = VGA_VSYNC_NEG && !vs_q;
    assign vs_fall  = !VGA_VSYNC_NEG && vs_q;
    assign y_chg_unused_guard = 1'b0;

    assign x0 = PIXEL_X[XW-1:0];
    assign x1 = x0 - X_ONE;
    assign x2 = x0 - X_TWO;

    assign rows_b_n = advance(rows_b, y_chg, in_roi && blue_f, PIXEL_X);
    assign rows_r_n = advance(rows_r, y_chg, in_roi && red_f, PIXEL_X);
    assign win_b    = window(rows_b_n, x2, x1, x0);
    assign win_r    = window(rows_r_n, x2, x1, x0);
    assign up_b     = in_roi && interior && up_hit(win_b);
    assign dn_b     = in_roi && interior && dn_hit(win_b);
    assign up_r     = in_roi && interior && up_hit(win_r);
    assign dn_r     = in_roi && interior && dn_hit(win_r);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        clr_raw = 1'b0;
        case (state)
            ST_WAIT: if (vs_rise) begin
                state_n = ST_ACCUM;
                clr_raw = 1'b1;
            end
            ST_ACCUM:  if (vs_fall) state_n = ST_FILT;
            ST_FILT:   state_n = ST_DECIDE;
            ST_DECIDE: state_n = ST_WAIT;
            default:   state_n = ST_WAIT;
        endcase
    end

    always_comb begin
        pix_d = PIXEL_IN;
        case (MODE)
            2'b01: pix_d = !in_roi ? 8'h00 : red_f ? 8'hE0 : blue_f ? 8'h03 : 8'h00;
            2'b10: pix_d = (up_r || dn_r) ? 8'hE0 : (up_b || dn_b) ? 8'h27 : 8'h00;
            default: pix_d = PIXEL_IN;
        endcase
    end

    always_comb begin
        cand = 3'b000;
        if ({1'b0, blue_p} > COL_TH_W)                          cand = 3'b001;
        if (({1'b0, blue_p} > COL_HALF) && (dn_b_p > TRI_TH_W)) cand = 3'b101;
        if (({1'b0, blue_p} > COL_HALF) && (up_b_p > DIA_TH_W)) cand = 3'b011;
        if ({1'b0, red_p} > COL_TH_W)                           cand = 3'b010;
        if (({1'b0, red_p} > COL_HALF) && (dn_r_p > TRI_TH_W))  cand = 3'b110;
        if (({1'b0, red_p} > COL_HALF) && (up_r_p > DIA_TH_W))  cand = 3'b100;
    end

    assign stab_next = (cand != last_cand)   ? STAB_ONE :
                       (stab_cnt == STAB_MAX) ? stab_cnt : stab_cnt + STAB_ONE;
    assign update    = (state == ST_DECIDE) && (stab_next == STAB_MAX) && (cand != RESULT);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= ST_WAIT;
            vs_q      <= 1'b1;  // a frame already in progress at reset is not treated as a start
            y_q       <= '0;
            // NOTE: the line buffers are ordinary flops and are cleared with everything else.
            rows_b    <= '0;
            rows_r    <= '0;
            PIXEL_OUT <= '0;
        end else begin
            state     <= state_n;
            vs_q      <= VGA_VSYNC_NEG;
            y_q       <= PIXEL_Y;
            rows_b    <= rows_b_n;
            rows_r    <= rows_r_n;
            PIXEL_OUT <= pix_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N || clr_raw) begin
            {blue_cnt, red_cnt}                     <= '0;
            {up_b_cnt, dn_b_cnt, up_r_cnt, dn_r_cnt} <= '0;
        end else if ((state == ST_ACCUM) && in_roi) begin
            if (blue_f && ~&blue_cnt) blue_cnt <= blue_cnt + CNT_ONE;
            if (red_f  && ~&red_cnt)  red_cnt  <= red_cnt + CNT_ONE;
            if (up_b && ~&up_b_cnt)   up_b_cnt <= up_b_cnt + DIAG_ONE;
            if (dn_b && ~&dn_b_cnt)   dn_b_cnt <= dn_b_cnt + DIAG_ONE;
            if (up_r && ~&up_r_cnt)   up_r_cnt <= up_r_cnt + DIAG_ONE;
            if (dn_r && ~&dn_r_cnt)   dn_r_cnt <= dn_r_cnt + DIAG_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            {blue_p, red_p}                 <= '0;
            {up_b_p, dn_b_p, up_r_p, dn_r_p} <= '0;
            last_cand    <= '0;
            stab_cnt     <= '0;
            RESULT       <= '0;
            RESULT_VALID <= 1'b0;
        end else begin
            if (state == ST_FILT) begin
                blue_p <= iir_cnt(blue_p, blue_cnt);
                red_p  <= iir_cnt(red_p, red_cnt);
                up_b_p <= iir_diag(up_b_p, up_b_cnt);
                dn_b_p <= iir_diag(dn_b_p, dn_b_cnt);
                up_r_p <= iir_diag(up_r_p, up_r_cnt);
                dn_r_p <= iir_diag(dn_r_p, dn_r_cnt);
            end
            if (state == ST_DECIDE) begin
                last_cand <= cand;
                stab_cnt  <= stab_next;
            end
            // A fresh result outranks a same-cycle acknowledge of the old one.
            if (update) begin
                RESULT       <= cand;
                RESULT_VALID <= 1'b1;
            end else if (RESULT_ACK && RESULT_VALID) begin
                RESULT_VALID <= y_chg_unused_guard;
            end
        end
    end

endmodule

// File: tb/tb_shape_color_classifier.sv
// Directed bench: reset, debug video modes, red stability voting, VALID/ACK handshake,
// blue diamond / triangle shapes, and 8-bit counter saturation on a second instance.
module tb_shape_color_classifier;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pixel_in;
    logic [9:0] pixel_x, pixel_y;
    logic       vsync_m, vsync_s;
    logic [1:0] mode;
    logic       ack;
    logic [7:0] pixel_out, pixel_out_s;
    logic [2:0] result, result_s;
    logic       result_valid, result_valid_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shape_color_classifier #(.IIR_SHIFT(0)) dut (
        .CLK(clk), .RST_N(rst_n), .PIXEL_IN(pixel_in), .PIXEL_X(pixel_x), .PIXEL_Y(pixel_y),
        .VGA_VSYNC_NEG(vsync_m), .MODE(mode), .RESULT_ACK(ack),
        .PIXEL_OUT(pixel_out), .RESULT(result), .RESULT_VALID(result_valid)
    );

    shape_color_classifier #(.IIR_SHIFT(0), .CNT_W(8), .COLOR_TH(200), .STABLE_FRAMES(1)) dut_sat (
        .CLK(clk), .RST_N(rst_n), .PIXEL_IN(pixel_in), .PIXEL_X(pixel_x), .PIXEL_Y(pixel_y),
        .VGA_VSYNC_NEG(vsync_s), .MODE(mode), .RESULT_ACK(1'b0),
        .PIXEL_OUT(pixel_out_s), .RESULT(result_s), .RESULT_VALID(result_valid_s)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] p, input int x, input int y);
        pixel_in = p;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        tick();
    endtask

    // Three line changes outside the ROI flush all flag rows before the frame body.
    task automatic frame_begin(input bit sat);
        if (sat) vsync_s = 1'b1; else vsync_m = 1'b1;
        drive(8'h1C, 0, 144);
        drive(8'h1C, 0, 145);
        drive(8'h1C, 0, 146);
    endtask

    // Fall edge, FILT, then DECIDE; optional ACK is sampled on the DECIDE edge.
    task automatic frame_end(input bit sat, input bit ack_on_decide);
        if (sat) vsync_s = 1'b0; else vsync_m = 1'b0;
        drive(8'h1C, 0, 144);
        tick();
        ack = ack_on_decide;
        tick();
        ack = 1'b0;
    endtask

    task automatic red_frame();
        frame_begin(0);
        for (int y = 0; y < 50; y++)
            for (int x = 36; x < 176; x++)
                drive(8'hE0, x, y);
        frame_end(0, 0);
    endtask

    // 45-degree square centred (100,50), radius 40: 3281 blue pixels, green fill to R+2.
    task automatic diamond_frame();
        frame_begin(0);
        for (int y = 10; y <= 90; y++) begin
            int w;
            w = (y < 50) ? 40 - (50 - y) : 40 - (y - 50);
            for (int x = 100 - w; x <= 100 + w + 2; x++)
                drive((x <= 100 + w) ? 8'h02 : 8'h1C, x, y);
        end
        frame_end(0, 0);
    endtask

    // Upright triangle, apex (100,20), 60 rows: 3600 blue pixels, only expanding edges.
    task automatic triangle_frame(input bit ack_on_decide);
        frame_begin(0);
        for (int k = 0; k < 60; k++)
            for (int x = 100 - k; x <= 100 + k + 2; x++)
                drive((x <= 100 + k) ? 8'h02 : 8'h1C, x, 20 + k);
        frame_end(0, ack_on_decide);
    endtask

    initial begin
        rst_n    = 1'b0;
        pixel_in = 8'hFF;
        pixel_x  = '0;
        pixel_y  = '0;
        vsync_m  = 1'b0;
        vsync_s  = 1'b0;
        mode     = 2'b00;
        ack      = 1'b0;

        tick();
        tick();
        check("rst_result", 8'(result), 8'h00);
        check("rst_valid", 8'(result_valid), 8'h00);
        check("rst_pixel_out", pixel_out, 8'h00);
        check("rst_sat_result", 8'(result_s), 8'h00);
        rst_n = 1'b1;

        drive(8'hA5, 0, 0);   check("mode00_a", pixel_out, 8'hA5);
        drive(8'h3C, 0, 0);   check("mode00_b", pixel_out, 8'h3C);
        mode = 2'b11;
        drive(8'h5A, 0, 0);   check("mode11", pixel_out, 8'h5A);

        mode = 2'b01;
        drive(8'hE0, 35, 10); check("mode01_x_eq_roi_min", pixel_out, 8'h00);
        drive(8'hE0, 36, 10); check("mode01_x_roi_min_p1", pixel_out, 8'hE0);
        drive(8'h02, 37, 10); check("mode01_blue", pixel_out, 8'h03);
        drive(8'h1C, 38, 10); check("mode01_other", pixel_out, 8'h00);
        drive(8'h20, 39, 10); check("mode01_red_wins", pixel_out, 8'hE0);
        drive(8'hE0, 50, 144); check("mode01_y_out", pixel_out, 8'h00);

        mode = 2'b10;
        drive(8'hE0, 50, 20); check("mode10_no_edge", pixel_out, 8'h00);
        drive(8'hE0, 60, 30); drive(8'hE0, 61, 30); drive(8'hE0, 62, 30);
        drive(8'hE0, 60, 31); drive(8'hE0, 61, 31); drive(8'h1C, 62, 31);
        drive(8'hE0, 60, 32); drive(8'h1C, 61, 32); drive(8'h1C, 62, 32);
        check("mode10_red_edge", pixel_out, 8'hE0);
        mode = 2'b00;

        red_frame();
        check("red_f1_result", 8'(result), 8'h00);
        check("red_f1_valid", 8'(result_valid), 8'h00);
        red_frame();
        check("red_f2_result", 8'(result), 8'h00);
        check("red_f2_valid", 8'(result_valid), 8'h00);
        red_frame();
        check("red_f3_result", 8'(result), 8'h02);
        check("red_f3_valid", 8'(result_valid), 8'h01);
        red_frame();
        check("red_f4_result", 8'(result), 8'h02);
        check("red_f4_valid_held", 8'(result_valid), 8'h01);

        ack = 1'b1; tick(); ack = 1'b0;
        check("ack_clears_valid", 8'(result_valid), 8'h00);
        check("ack_keeps_result", 8'(result), 8'h02);
        ack = 1'b1; tick(); ack = 1'b0; tick();
        check("ack_idle_valid", 8'(result_valid), 8'h00);
        check("ack_idle_result", 8'(result), 8'h02);

        diamond_frame();
        check("dia_f1_result", 8'(result), 8'h02);
        diamond_frame();
        check("dia_f2_valid", 8'(result_valid), 8'h00);
        diamond_frame();
        check("dia_f3_result", 8'(result), 8'h03);
        check("dia_f3_valid", 8'(result_valid), 8'h01);

        triangle_frame(0);
        check("tri_f1_result", 8'(result), 8'h03);
        triangle_frame(0);
        check("tri_f2_result", 8'(result), 8'h03);
        triangle_frame(1);
        check("tri_f3_ack_same_cycle_result", 8'(result), 8'h05);
        check("tri_f3_ack_same_cycle_valid", 8'(result_valid), 8'h01);
        ack = 1'b1; tick(); ack = 1'b0;
        check("tri_ack_clears", 8'(result_valid), 8'h00);

        check("sat_idle_result", 8'(result_s), 8'h00);
        frame_begin(1);
        for (int y = 0; y < 3; y++)
            for (int x = 36; x < 176; x++)
                drive(8'h02, x, y);
        frame_end(1, 0);
        check("sat_blue_no_wrap", 8'(result_s), 8'h01);
        check("sat_valid", 8'(result_valid_s), 8'h01);
        check("main_untouched_by_sat", 8'(result), 8'h05);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
